// File: rtl/multi_input_debounce.sv
// multi_input_debounce: per-channel synchroniser plus stability-qualified FSM with registered level and edge strobes
module multi_input_debounce #(
  parameter int par_num_inputs    = 4,
  parameter int par_stable_cycles = 100000
) (
  input  logic                      i_clk_mhz,
  input  logic                      i_rst_mhz,
  input  logic [par_num_inputs-1:0] ei_inputs,
  output logic [par_num_inputs-1:0] o_inputs_deb,
  output logic [par_num_inputs-1:0] o_inputs_rise,
  output logic [par_num_inputs-1:0] o_inputs_fall
);
  localparam int cw = $clog2(par_stable_cycles);
  localparam logic [cw-1:0] last = cw'(par_stable_cycles - 1);
  typedef enum logic [1:0] {ST_LOW, ST_RISE_WAIT, ST_HIGH, ST_FALL_WAIT} state_t;
  logic [par_num_inputs-1:0] meta, sync;
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= ei_inputs;
      sync <= meta;
    end
  end
  for (genvar g = 0; g < par_num_inputs; g++) begin : g_ch
    state_t state, state_n;
    logic [cw-1:0] cnt, cnt_n;
    logic deb, rise, fall, deb_n, rise_n, fall_n;
    always_ff @(posedge i_clk_mhz) begin
      if (i_rst_mhz) begin
        state <= ST_LOW;
        cnt   <= '0;
        deb   <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        deb   <= deb_n;
        rise  <= rise_n;
        fall  <= fall_n;
      end
    end
    // The wait states count while sync holds the new level; any reversion drops back with the count discarded
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      deb_n   = deb;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      case (state)
        ST_LOW: if (sync[g]) begin
          state_n = ST_RISE_WAIT;
          cnt_n   = '0;
        end
        ST_RISE_WAIT: if (!sync[g]) begin
          state_n = ST_LOW;
          cnt_n   = '0;
        end else if (cnt == last) begin
          state_n = ST_HIGH;
          cnt_n   = '0;
          deb_n   = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        ST_HIGH: if (!sync[g]) begin
          state_n = ST_FALL_WAIT;
          cnt_n   = '0;
        end
        default: if (sync[g]) begin
          state_n = ST_HIGH;
          cnt_n   = '0;
        end else if (cnt == last) begin
          state_n = ST_LOW;
          cnt_n   = '0;
          deb_n   = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      endcase
    end
    assign o_inputs_deb[g]  = deb;
    assign o_inputs_rise[g] = rise;
    assign o_inputs_fall[g] = fall;
  end
endmodule

// File: tb/tb_multi_input_debounce.sv
// tb_multi_input_debounce: directed and randomized checks against a run-length reference model
module tb_multi_input_debounce;
  localparam int N = 4;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] in = '0;
  logic [N-1:0] deb, rise, fall;
  logic [N-1:0] meta_m = '0, sync_m = '0, deb_m = '0, rise_m = '0, fall_m = '0;
  int run [N];
  int checks = 0;
  int failures = 0;

  multi_input_debounce #(.par_num_inputs(N), .par_stable_cycles(P)) dut (
    .i_clk_mhz(clk),
    .i_rst_mhz(rst),
    .ei_inputs(in),
    .o_inputs_deb(deb),
    .o_inputs_rise(rise),
    .o_inputs_fall(fall)
  );

  always #5 clk = ~clk;

  // A level is accepted once the sampled synchronised value has differed from it for P+1 consecutive edges
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      meta_m = '0; sync_m = '0; deb_m = '0; rise_m = '0; fall_m = '0;
      for (int b = 0; b < N; b++) run[b] = 0;
    end else begin
      for (int b = 0; b < N; b++) begin
        rise_m[b] = 1'b0;
        fall_m[b] = 1'b0;
        run[b] = (sync_m[b] != deb_m[b]) ? run[b] + 1 : 0;
        if (run[b] == P + 1) begin
          deb_m[b]  = ~deb_m[b];
          rise_m[b] = deb_m[b];
          fall_m[b] = ~deb_m[b];
          run[b]    = 0;
        end
      end
      sync_m = meta_m;
      meta_m = in;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = '0;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({deb, rise, fall} !== 12'h000) begin
        failures++;
        $display("FAIL reset e=%0d got=%h want=000", e, {deb, rise, fall});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rise_latency();
    in[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if ({deb, rise, fall} !== {deb_m, rise_m, fall_m}) begin
        failures++;
        $display("FAIL latency_model e=%0d got=%h want=%h", e, {deb, rise, fall}, {deb_m, rise_m, fall_m});
      end
      checks++;
      if ({deb[0], rise[0]} !== ((e < 6) ? 2'b00 : (e == 6) ? 2'b11 : 2'b10)) begin
        failures++;
        $display("FAIL latency_bit0 e=%0d got deb=%b rise=%b", e, deb[0], rise[0]);
      end
      checks++;
      if ({deb[3:1], rise[3:1], fall} !== 10'h0) begin
        failures++;
        $display("FAIL latency_others e=%0d got=%h want=0", e, {deb[3:1], rise[3:1], fall});
      end
    end
  endtask

  task automatic test_glitch();
    int first;
    in[1] = 1'b1;
    for (int e = 0; e < 11; e++) begin
      if (e == 3) in[1] = 1'b0;
      tick();
      checks++;
      if (deb[1] !== 1'b0 || rise[1] !== 1'b0 || {deb, rise, fall} !== {deb_m, rise_m, fall_m}) begin
        failures++;
        $display("FAIL glitch e=%0d got=%h want=%h", e, {deb, rise, fall}, {deb_m, rise_m, fall_m});
      end
    end
    in[1] = 1'b1;
    first = -1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (first < 0 && deb[1] === 1'b1) first = e;
    end
    checks++;
    if (first != 6) begin
      failures++;
      $display("FAIL glitch_requalify got edge=%0d want=6", first);
    end
  endtask

  task automatic test_fall_bounce();
    int first, n;
    bit early;
    in[2] = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    in[2] = 1'b0; tick();
    in[2] = 1'b1; tick(); tick();
    in[2] = 1'b0;
    first = -1; n = 0; early = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (fall[2] === 1'b1) begin n++; if (first < 0) first = e; end
      if (e < 6 && deb[2] !== 1'b1) early = 1'b1;
      checks++;
      if ({deb, rise, fall} !== {deb_m, rise_m, fall_m}) begin
        failures++;
        $display("FAIL bounce_model e=%0d got=%h want=%h", e, {deb, rise, fall}, {deb_m, rise_m, fall_m});
      end
    end
    checks++;
    if (first != P + 2 || n != 1 || early) begin
      failures++;
      $display("FAIL bounce_fall got edge=%0d count=%0d early=%0d want edge=6 count=1 early=0", first, n, early);
    end
  endtask

  task automatic test_simultaneous();
    int e0, e3, n0, n3;
    in = '0;
    for (int e = 0; e < 8; e++) tick();
    in[0] = 1'b1; in[3] = 1'b1;
    e0 = -1; e3 = -1; n0 = 0; n3 = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (rise[0] === 1'b1) begin n0++; e0 = e; end
      if (rise[3] === 1'b1) begin n3++; e3 = e; end
    end
    checks++;
    if (e0 != 6 || e3 != 6 || n0 != 1 || n3 != 1) begin
      failures++;
      $display("FAIL simultaneous got e0=%0d e3=%0d n0=%0d n3=%0d want 6 6 1 1", e0, e3, n0, n3);
    end
  endtask

  task automatic test_reset_held();
    int first;
    in = '0;
    for (int e = 0; e < 8; e++) tick();
    rst = 1'b1; in[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if ({deb, rise, fall} !== 12'h000) begin
        failures++;
        $display("FAIL reset_held e=%0d got=%h want=000", e, {deb, rise, fall});
      end
    end
    rst = 1'b0;
    first = -1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (first < 0 && rise[0] === 1'b1) first = e;
    end
    checks++;
    if (first != 6) begin
      failures++;
      $display("FAIL reset_held_rise got edge=%0d want=6", first);
    end
  endtask

  task automatic test_reset_mid();
    int first, n;
    in = '0;
    for (int e = 0; e < 8; e++) tick();
    in[3] = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    rst = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({deb, rise, fall} !== 12'h000) begin
        failures++;
        $display("FAIL reset_mid e=%0d got=%h want=000", e, {deb, rise, fall});
      end
    end
    rst = 1'b0;
    first = -1; n = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (rise[3] === 1'b1) begin n++; if (first < 0) first = e; end
    end
    checks++;
    if (first != 6 || n != 1) begin
      failures++;
      $display("FAIL reset_mid_rise got edge=%0d count=%0d want edge=6 count=1", first, n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) in[b] = ~in[b];
      rst = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if ({deb, rise, fall} !== {deb_m, rise_m, fall_m}) begin
        failures++;
        $display("FAIL random c=%0d got=%h want=%h", c, {deb, rise, fall}, {deb_m, rise_m, fall_m});
      end
      checks++;
      if ((rise & fall) !== '0) begin
        failures++;
        $display("FAIL random_both c=%0d rise=%b fall=%b", c, rise, fall);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < N; b++) run[b] = 0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall_bounce();
    test_simultaneous();
    test_reset_held();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
